// File: rtl/layer_stream.sv
// Streamed fully-connected layer: NN MAC lanes share one input sample stream and
// the activated results leave one neuron per beat over a valid/ready interface.
module layer_stream #(
  parameter  int NN        = 30,
  parameter  int numWeight = 784,
  parameter  int dataWidth = 16,
  parameter  int fracBits  = 8,
  parameter  int layerNum  = 1,
  localparam int IW        = (NN > 1) ? $clog2(NN) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        weightValid,
  input  logic                        biasValid,
  input  logic [31:0]                 weightValue,
  input  logic [31:0]                 biasValue,
  input  logic [31:0]                 config_layer_num,
  input  logic [31:0]                 config_neuron_num,
  input  logic                        act_mode,
  input  logic                        x_valid,
  output logic                        x_ready,
  input  logic signed [dataWidth-1:0] x_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [dataWidth-1:0] out_data,
  output logic [IW-1:0]               out_idx,
  output logic                        out_last
);

  localparam int CW = (numWeight > 1) ? $clog2(numWeight) : 1;
  localparam int PW = 2 * dataWidth;
  localparam int AW = PW + $clog2(numWeight);
  localparam int SW = AW + 1;
  localparam logic signed [SW-1:0] SAT_HI = SW'((64'sd1 <<< (dataWidth - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FLUSH, S_WAIT} state_t;

  state_t                      r_state;
  logic [CW-1:0]               r_cnt;
  logic                        r_act;
  logic                        r_v1, r_f1, r_l1;
  logic                        r_v2, r_f2, r_l2;
  logic                        r_fin;
  logic signed [dataWidth-1:0] r_x1;
  logic signed [dataWidth-1:0] r_buf [NN];
  logic signed [dataWidth-1:0] w_res [NN];

  logic          w_x_acc;
  logic          w_last_beat;
  logic          w_cfg_ok;
  logic          w_buf_free;
  logic          w_buf_wr;
  logic [IW-1:0] w_nidx;
  logic          w_unused;

  assign w_x_acc     = x_valid & x_ready;
  assign w_last_beat = w_x_acc && (r_cnt == CW'(numWeight - 1));
  // Config writes only land between frames so a frame never sees mixed weights.
  assign w_cfg_ok    = (r_state == S_IDLE) && (config_layer_num == 32'(layerNum));
  assign w_buf_free  = !out_valid || (out_ready && out_last);
  assign w_buf_wr    = ((r_state == S_FLUSH && r_fin) || r_state == S_WAIT) && w_buf_free;
  assign w_nidx      = out_idx + 1'b1;
  assign w_unused    = ^{weightValue[31:dataWidth], biasValue[31:dataWidth]};

  for (genvar n = 0; n < NN; n++) begin : g_lane
    logic signed [dataWidth-1:0] r_wmem [numWeight];
    logic signed [dataWidth-1:0] r_wrd;
    logic signed [dataWidth-1:0] r_bias;
    logic [CW-1:0]               r_wptr;
    logic signed [PW-1:0]        r_prod;
    logic signed [AW-1:0]        r_acc;
    logic signed [SW-1:0]        w_sum;
    logic signed [SW-1:0]        w_shr;
    logic signed [dataWidth-1:0] w_sat;
    logic                        w_hit;

    assign w_hit = w_cfg_ok && (config_neuron_num == 32'(n));

    // NOTE: weight RAM and bias carry no reset so the array maps onto block RAM;
    // their contents are only meaningful once loaded over the config bus.
    always_ff @(posedge clk) begin
      if (w_hit && weightValid) r_wmem[r_wptr] <= weightValue[dataWidth-1:0];
      if (w_hit && biasValid)   r_bias         <= biasValue[dataWidth-1:0];
      r_wrd <= r_wmem[r_cnt];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wptr <= '0;
        r_prod <= '0;
        r_acc  <= '0;
      end else begin
        if (w_hit && weightValid)
          r_wptr <= (r_wptr == CW'(numWeight - 1)) ? '0 : r_wptr + 1'b1;
        if (r_v1) r_prod <= PW'(r_x1) * PW'(r_wrd);
        if (r_v2) r_acc  <= r_f2 ? AW'(r_prod) : r_acc + AW'(r_prod);
      end
    end

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
      w_sum = SW'(r_acc) + (SW'(r_bias) <<< fracBits);
      w_shr = w_sum >>> fracBits;
      if (w_shr > SAT_HI)      w_sat = SAT_HI[dataWidth-1:0];
      else if (w_shr < SAT_LO) w_sat = SAT_LO[dataWidth-1:0];
      else                     w_sat = w_shr[dataWidth-1:0];
      if (r_act && w_sat[dataWidth-1]) w_sat = '0;
    end

    assign w_res[n] = w_sat;
  end

  always_ff @(posedge clk) begin
    if (w_buf_wr)
      for (int n = 0; n < NN; n++) r_buf[n] <= w_res[n];
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_act     <= 1'b0;
      x_ready   <= 1'b1;
      r_v1      <= 1'b0;
      r_f1      <= 1'b0;
      r_l1      <= 1'b0;
      r_x1      <= '0;
      r_v2      <= 1'b0;
      r_f2      <= 1'b0;
      r_l2      <= 1'b0;
      r_fin     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      r_v1  <= w_x_acc;
      r_f1  <= w_x_acc && (r_cnt == '0);
      r_l1  <= w_last_beat;
      r_x1  <= x_in;
      r_v2  <= r_v1;
      r_f2  <= r_f1;
      r_l2  <= r_l1;
      r_fin <= r_v2 && r_l2;

      if (w_x_acc) begin
        r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
        if (r_cnt == '0) r_act <= act_mode;
      end

      unique case (r_state)
        S_IDLE: begin
          x_ready <= 1'b1;
          if (w_x_acc) r_state <= S_ACC;
        end
        S_ACC:   ;
        S_FLUSH: if (r_fin) r_state <= w_buf_free ? S_IDLE : S_WAIT;
        S_WAIT:  if (w_buf_free) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // Input stays closed from the last beat until the result has been buffered.
      if (w_last_beat) begin
        r_state <= S_FLUSH;
        x_ready <= 1'b0;
      end

      if (w_buf_wr) begin
        out_valid <= 1'b1;
        out_idx   <= '0;
        out_data  <= w_res[0];
        out_last  <= (NN == 1);
      end else if (out_valid && out_ready) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          out_idx  <= w_nidx;
          out_data <= r_buf[w_nidx];
          out_last <= (w_nidx == IW'(NN - 1));
        end
      end
    end
  end

endmodule

// File: doc/layer_stream.md
# layer_stream

Time-streamed fully-connected layer: NN parallel MAC lanes share one input stream of numWeight samples per frame. Each lane holds on-chip weights and a bias loaded over the existing config bus, and applies a runtime-selected activation. Results go into an output buffer and leave serially on a valid/ready stream, so layers chain without a wide parallel bus. It sits between consecutive layers of the network top, replacing the parallel-output layer instance where a streamed interface is wanted.

## Interface
- NN, 30, number of neurons (lanes)
- numWeight, 784, inputs per frame (weights per neuron)
- dataWidth, 16, signed data/weight/bias width
- fracBits, 8, fractional bits of the fixed-point format
- layerNum, 1, layer id matched against config_layer_num
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- weightValid  in  1  weight write strobe
- biasValid  in  1  bias write strobe
- weightValue  in  32  weight, low dataWidth bits used
- biasValue  in  32  bias, low dataWidth bits used
- config_layer_num  in  32  target layer of write
- config_neuron_num  in  32  target neuron of write
- act_mode  in  1  0 = identity, 1 = ReLU; sampled on first input beat of a frame
- x_valid  in  1  input sample valid
- x_ready  out  1  input sample accepted when x_valid & x_ready
- x_in  in  dataWidth  signed input sample
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  dataWidth  activated neuron result
- out_idx  out  clog2(NN)  neuron index of out_data
- out_last  out  1  high on beat with out_idx == NN-1

## Operation
- Config: a write whose config_layer_num == layerNum and config_neuron_num < NN takes effect. A weightValid write stores to the neuron's next address; each neuron has its own write pointer that increments and wraps at numWeight. A biasValid write overwrites the bias. Writes are dropped while a frame is in progress (input counter ≠ 0 or pipeline not drained). Out-of-range neuron numbers are ignored.
- States: IDLE (counter 0), ACC (counter 1..numWeight-1), FLUSH (pipeline draining after last beat), WAIT (result ready, output buffer still occupied).
- Transitions:
  - IDLE→ACC on the first accepted beat.
  - ACC→FLUSH on the accepted beat with counter == numWeight-1.
  - FLUSH→IDLE when the result is written to the buffer.
  - FLUSH→WAIT if the buffer is busy at that point.
  - WAIT→IDLE on the write to the buffer.
- MAC: beat k multiplies x_in by weight[k] into a 2·dataWidth product. The accumulator is AW = 2·dataWidth + clog2(numWeight) bits, signed, so it cannot overflow. It clears on the first beat of a frame.
- Finalise:
  - sum = acc + (sign-extended bias <<< fracBits).
  - r = sum >>> fracBits (arithmetic shift).
  - Saturate r to [−2^(dataWidth−1), 2^(dataWidth−1)−1].
  - If act_mode was 1 and r < 0, r = 0.
- Output buffer: one frame of NN results. It drains index 0..NN-1, one beat per out_valid & out_ready. Once full it becomes free after the out_last beat is accepted.
- The next frame accumulates while the previous frame drains. The buffer write occurs in the same cycle as the final out_last handshake if both coincide.

## Timing
- Reset values: x_ready = 1, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0. Counters, write pointers and accumulators are 0, state is IDLE. Weights and biases are not reset.
- The weight RAM is synchronous read.
- Pipeline for a beat accepted at cycle t: weight read at t+1, product registered at t+2, accumulator updated at t+3.
- Last beat accepted at t with the buffer free: buffer loaded and out_valid = 1 at t+4, with out_idx = 0.
- x_ready is 0 from t+1 until the cycle after the buffer write. With no stall this is t+5, giving a minimum frame period of numWeight+4 cycles.
- out_data, out_idx and out_last hold stable while out_valid & !out_ready.
- Reset asserted mid-frame or mid-drain: all outputs return to their reset values immediately, and the partial frame and buffered results are discarded.

## Test plan
- NN=2, numWeight=3. Weights n0 = {256,256,256} with bias 0, n1 = {−256,0,0} with bias 128. x = {256,512,−256}. With act_mode = 0 the output is beats (0, 512) and (1, −128, last). With act_mode = 1 the second beat is 0.
- Saturation: all weights 32767, all x 32767, bias 32767 → out_data 32767. With all weights −32768 and x 32767 in identity mode → −32768.
- Latency: with out_ready tied 1, out_valid rises exactly 4 cycles after the last beat is accepted. x_ready is low for exactly 4 cycles.
- Backpressure: hold out_ready = 0 and stream frame 2 fully. x_ready stays low after frame 2's last beat until frame 1's out_last is accepted. Frame 2 results then appear intact with the correct values.
- Config: writes with the wrong layerNum, neuron ≥ NN, or sent mid-frame leave results unchanged. Three weight writes after a frame restart the write pointer at index 0 (wrap).
- Reset mid-frame after 2 beats: outputs go to their reset values, and a fresh full frame produces the expected results from the first test.
